// File: rtl/perip_tone_env.sv
// Memory-mapped tone generator: a 24-bit phase accumulator feeds one of three waveforms,
// the waveform is scaled by an attack/sustain/release envelope, and each sample goes out with a one-cycle strobe.
module perip_tone_env #(
  parameter int unsigned SAMPLE_DIV = 1042
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic [7:0]  sample,
  output logic        sample_valid
);

  localparam int unsigned STAGES  = 1;
  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0] LVL_MAX  = 16'hFFFF;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_PINC = 3'd1;
  localparam logic [2:0] A_ATT  = 3'd2;
  localparam logic [2:0] A_REL  = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;
  localparam logic [2:0] A_SAMP = 3'd5;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_e;

  typedef struct packed {
    logic [1:0] wave;
    logic       gate;
    logic       enable;
  } ctrl_t;

  ctrl_t       ctrl_q;
  logic [23:0] phase_inc_q;
  logic [15:0] attack_q, release_q;

  logic [15:0] div_q;
  logic [23:0] phase_q, phase_d;
  env_e        state_q, state_d;
  logic [15:0] level_q, level_d;
  logic [16:0] att_sum;
  logic [7:0]  p, wave_val;
  logic [15:0] product;
  logic [7:0]  stage_q, stage_d;
  logic [STAGES:0] vld_pipe_q;
  logic [7:0]  sample_q;
  logic [31:0] d_out_q, rdata;

  logic [2:0]  reg_sel;
  logic        wr_en, rd_en, tick;
  logic        unused_bits;

  assign reg_sel     = addr[4:2];
  assign wr_en       = cs & wr;
  assign rd_en       = cs & rd;
  assign tick        = ctrl_q.enable && (div_q == DIV_LAST);
  assign unused_bits = ^{addr[31:5], addr[1:0], d_in[31:24]};

  // Register file; STATUS and SAMPLE are read-only, unmapped offsets swallow writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q      <= '0;
      phase_inc_q <= '0;
      attack_q    <= '0;
      release_q   <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        A_CTRL:  ctrl_q      <= ctrl_t'(d_in[3:0]);
        A_PINC:  phase_inc_q <= d_in[23:0];
        A_ATT:   attack_q    <= d_in[15:0];
        A_REL:   release_q   <= d_in[15:0];
        default: ;
      endcase
    end
  end

  // Envelope next-state; only moves on a sample tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    att_sum = {1'b0, level_q} + {1'b0, attack_q};
    if (tick) begin
      case (state_q)
        ENV_IDLE: begin
          level_d = '0;
          if (ctrl_q.gate) state_d = ENV_ATTACK;
        end
        ENV_ATTACK: begin
          if (!ctrl_q.gate) begin
            state_d = ENV_RELEASE;
          end else if (attack_q == '0 || att_sum >= 17'h0FFFF) begin
            level_d = LVL_MAX;
            state_d = ENV_SUSTAIN;
          end else begin
            level_d = att_sum[15:0];
          end
        end
        ENV_SUSTAIN: begin
          level_d = LVL_MAX;
          if (!ctrl_q.gate) state_d = ENV_RELEASE;
        end
        ENV_RELEASE: begin
          if (ctrl_q.gate) begin
            state_d = ENV_ATTACK;
          end else if (release_q == '0 || level_q <= release_q) begin
            level_d = '0;
            state_d = ENV_IDLE;
          end else begin
            level_d = level_q - release_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENV_IDLE;
      level_q <= '0;
    end else if (!ctrl_q.enable) begin
      state_q <= ENV_IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Sample is formed at the tick edge from the post-tick phase/level so the wave
  // select in force during the tick cycle is the one that shapes it.
  always_comb begin
    phase_d = phase_q + phase_inc_q;
    p       = phase_d[23:16];
    case (ctrl_q.wave)
      2'b01:   wave_val = p;
      2'b10:   wave_val = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      default: wave_val = p[7] ? 8'h00 : 8'hFF;
    endcase
    product = {8'h00, wave_val} * {8'h00, level_d[15:8]};
    stage_d = product[15:8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      phase_q    <= '0;
      stage_q    <= '0;
      vld_pipe_q <= '0;
      sample_q   <= '0;
    end else if (!ctrl_q.enable) begin
      div_q      <= '0;
      phase_q    <= '0;
      stage_q    <= '0;
      vld_pipe_q <= '0;
      sample_q   <= '0;
    end else begin
      div_q      <= tick ? '0 : div_q + 16'd1;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], tick};
      if (tick) begin
        phase_q <= phase_d;
        stage_q <= stage_d;
      end
      if (vld_pipe_q[0]) sample_q <= stage_q;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      A_CTRL:  rdata = {28'h0, ctrl_q};
      A_PINC:  rdata = {8'h0, phase_inc_q};
      A_ATT:   rdata = {16'h0, attack_q};
      A_REL:   rdata = {16'h0, release_q};
      A_STAT:  rdata = {level_q, 14'h0, state_q};
      A_SAMP:  rdata = {24'h0, sample_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      d_out_q <= '0;
    else if (rd_en) d_out_q <= rdata;
  end

  assign d_out        = d_out_q;
  assign sample       = sample_q;
  assign sample_valid = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_perip_tone_env.sv
// Bench for perip_tone_env: scripted and random notes scored against a per-tick envelope/waveform model.
module tb_perip_tone_env;

  localparam int DIV    = 4;
  localparam int R_CTRL = 0;
  localparam int R_PINC = 1;
  localparam int R_ATT  = 2;
  localparam int R_REL  = 3;
  localparam int R_STAT = 4;
  localparam int R_SAMP = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] d_in = '0;
  logic        cs = 1'b0;
  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] d_out;
  logic [7:0]  sample;
  logic        sample_valid;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // model of the programmed registers and the note in flight
  int m_phase, m_level, m_state, m_last;
  int m_inc, m_att, m_rel, m_gate, m_wave;

  perip_tone_env #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .sample(sample), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // bus tasks are entered at a negedge and return at the following negedge
  task automatic bus_write(input int idx, input logic [31:0] v);
    cs = 1'b1; wr = 1'b1; addr = 32'h0043_0000 + 32'(idx * 4); d_in = v;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input int idx, output logic [31:0] v);
    cs = 1'b1; rd = 1'b1; addr = 32'h0043_0000 + 32'(idx * 4);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    v = d_out;
  endtask

  task automatic wait_pulse(output bit got, output logic [7:0] s, output int c);
    got = 1'b0; s = '0; c = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sample_valid) begin got = 1'b1; s = sample; c = cyc; end
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_level = 0; m_state = 0; m_last = 0;
  endtask

  // one sample tick as the envelope rules describe it, then the emitted sample
  task automatic model_tick();
    int p, w;
    m_phase = (m_phase + m_inc) % (1 << 24);
    case (m_state)
      0: if (m_gate != 0) m_state = 1;
      1: if (m_gate == 0) m_state = 3;
         else if (m_att == 0 || m_level + m_att >= 65535) begin m_level = 65535; m_state = 2; end
         else m_level = m_level + m_att;
      2: if (m_gate == 0) m_state = 3;
      default: if (m_gate != 0) m_state = 1;
         else if (m_rel == 0 || m_level <= m_rel) begin m_level = 0; m_state = 0; end
         else m_level = m_level - m_rel;
    endcase
    p = (m_phase / 65536) % 256;
    if (m_wave == 1)      w = p;
    else if (m_wave == 2) w = (p >= 128) ? 255 - 2 * (p % 128) : 2 * (p % 128);
    else                  w = (p >= 128) ? 0 : 255;
    m_last = (w * (m_level / 256)) / 256;
  endtask

  function automatic logic [31:0] model_status();
    return {16'(m_level), 14'h0, 2'(m_state)};
  endfunction

  function automatic logic [31:0] ctrl_word(input int en);
    return 32'(m_wave * 4 + m_gate * 2 + en);
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    int npulse = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sample !== 8'h00 || sample_valid !== 1'b0 || d_out !== 32'h0) begin
      $display("FAIL reset_outputs: sample=%h valid=%b d_out=%h, want 0", sample, sample_valid, d_out);
    end else passed++;
    reset = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      bus_read(r, v);
      checks++;
      if (v !== 32'h0) $display("FAIL reset_read[%0d]: got %h want 0", r, v);
      else passed++;
    end
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (sample_valid) npulse++;
    end
    checks++;
    if (npulse != 0) $display("FAIL reset_no_pulse: got %0d pulses want 0", npulse);
    else passed++;
  endtask

  task automatic test_regs();
    logic [31:0] w, v;
    w = $urandom; bus_write(R_PINC, w); bus_read(R_PINC, v);
    checks++;
    if (v !== {8'h0, w[23:0]}) $display("FAIL reg_pinc: got %h want %h", v, {8'h0, w[23:0]});
    else passed++;
    w = $urandom; bus_write(R_ATT, w); bus_read(R_ATT, v);
    checks++;
    if (v !== {16'h0, w[15:0]}) $display("FAIL reg_attack: got %h want %h", v, {16'h0, w[15:0]});
    else passed++;
    w = $urandom; bus_write(R_REL, w); bus_read(R_REL, v);
    checks++;
    if (v !== {16'h0, w[15:0]}) $display("FAIL reg_release: got %h want %h", v, {16'h0, w[15:0]});
    else passed++;
    w = $urandom & 32'hFFFF_FFFE; bus_write(R_CTRL, w); bus_read(R_CTRL, v);
    checks++;
    if (v !== {28'h0, w[3:0]}) $display("FAIL reg_ctrl: got %h want %h", v, {28'h0, w[3:0]});
    else passed++;
    for (int r = 4; r < 8; r++) begin
      bus_write(r, $urandom);
      bus_read(r, v);
      checks++;
      if (v !== 32'h0) $display("FAIL reg_readonly[%0d]: got %h want 0", r, v);
      else passed++;
    end
  endtask

  task automatic test_square();
    bit got; logic [7:0] s; int c, prev;
    logic [31:0] v;
    prev = 0;
    bus_write(R_CTRL, 0); model_reset();
    m_inc = 32'h100000; m_att = 0; m_rel = 0; m_gate = 1; m_wave = 0;
    bus_write(R_PINC, m_inc); bus_write(R_ATT, 0); bus_write(R_REL, 0);
    bus_write(R_CTRL, ctrl_word(1));
    for (int i = 0; i < 24; i++) begin
      wait_pulse(got, s, c);
      model_tick();
      checks++;
      if (!got || s !== 8'(m_last)) $display("FAIL square_sample[%0d]: got %h (pulse=%0d) want %h", i, s, got, 8'(m_last));
      else passed++;
      if (i > 0) begin
        checks++;
        if (c - prev != DIV) $display("FAIL square_spacing[%0d]: got %0d want %0d", i, c - prev, DIV);
        else passed++;
      end
      prev = c;
      if (i % 4 == 0) begin
        bus_read(R_STAT, v);
        checks++;
        if (v !== model_status()) $display("FAIL square_status[%0d]: got %h want %h", i, v, model_status());
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    bit got, found; logic [7:0] s; int c;
    logic [31:0] v;
    int npulse = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      wait_pulse(got, s, c);
      if (got && s == 8'hFE) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL async_find_note: got no 0xFE sample want one within 20 pulses");
    else passed++;
    bus_read(R_CTRL, v);
    checks++;
    if (v !== 32'h3) $display("FAIL async_ctrl_read: got %h want 00000003", v);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sample !== 8'h00 || sample_valid !== 1'b0 || d_out !== 32'h0)
      $display("FAIL async_reset_outputs: sample=%h valid=%b d_out=%h want 0", sample, sample_valid, d_out);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(R_CTRL, v);
    checks++;
    if (v !== 32'h0) $display("FAIL async_ctrl_cleared: got %h want 0", v);
    else passed++;
    bus_read(R_PINC, v);
    checks++;
    if (v !== 32'h0) $display("FAIL async_pinc_cleared: got %h want 0", v);
    else passed++;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (sample_valid) npulse++;
    end
    checks++;
    if (npulse != 0) $display("FAIL async_no_pulse: got %0d want 0", npulse);
    else passed++;
  endtask

  // saw attack to sustain, release, retrigger mid-release, release to idle
  task automatic test_attack_release();
    bit got; logic [7:0] s; int c, prev, phase_no;
    logic [31:0] v;
    prev = 0; phase_no = 0;
    bus_write(R_CTRL, 0); model_reset();
    m_inc = 32'h800000; m_att = 32'h4000; m_rel = 32'h6000; m_gate = 1; m_wave = 1;
    bus_write(R_PINC, m_inc); bus_write(R_ATT, m_att); bus_write(R_REL, m_rel);
    bus_write(R_CTRL, ctrl_word(1));
    for (int i = 0; i < 16; i++) begin
      wait_pulse(got, s, c);
      model_tick();
      checks++;
      if (!got || s !== 8'(m_last)) $display("FAIL env_sample[%0d]: got %h (pulse=%0d) want %h", i, s, got, 8'(m_last));
      else passed++;
      if (i > 0) begin
        checks++;
        if (c - prev != DIV) $display("FAIL env_spacing[%0d]: got %0d want %0d", i, c - prev, DIV);
        else passed++;
      end
      prev = c;
      if ((phase_no == 0 || phase_no == 2) && m_state == 2) begin
        m_gate = 0; bus_write(R_CTRL, ctrl_word(1)); phase_no++;
      end else if (phase_no == 1 && m_state == 3 && m_level == 32'h9FFF) begin
        m_att = 32'h8000; bus_write(R_ATT, m_att);
        m_gate = 1; bus_write(R_CTRL, ctrl_word(1)); phase_no++;
      end
      bus_read(R_STAT, v);
      checks++;
      if (v !== model_status()) $display("FAIL env_status[%0d]: got %h want %h", i, v, model_status());
      else passed++;
    end
    checks++;
    if (phase_no != 3) $display("FAIL env_script: reached step %0d want 3", phase_no);
    else passed++;
  endtask

  task automatic test_enable_clear();
    bit got; logic [7:0] s; int c, npulse;
    logic [31:0] v;
    bus_write(R_CTRL, 0); model_reset();
    m_inc = $urandom_range(1, 32'hFFFFFF); m_att = 32'h3000; m_rel = 32'h1000;
    m_gate = 1; m_wave = $urandom_range(0, 3);
    bus_write(R_PINC, m_inc); bus_write(R_ATT, m_att); bus_write(R_REL, m_rel);
    bus_write(R_CTRL, ctrl_word(1));
    for (int i = 0; i < 7; i++) begin
      wait_pulse(got, s, c);
      model_tick();
      checks++;
      if (!got || s !== 8'(m_last)) $display("FAIL en_sample[%0d]: got %h want %h", i, s, 8'(m_last));
      else passed++;
    end
    // clear enable exactly on the next tick edge: that tick's pulse must not appear
    @(negedge clk); @(negedge clk);
    bus_write(R_CTRL, ctrl_word(0));
    model_reset();
    npulse = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sample_valid) npulse++;
    end
    checks++;
    if (npulse != 0) $display("FAIL en_cancel_pulse: got %0d pulses want 0", npulse);
    else passed++;
    checks++;
    if (sample !== 8'h00) $display("FAIL en_cancel_sample: got %h want 00", sample);
    else passed++;
    bus_read(R_STAT, v);
    checks++;
    if (v !== model_status()) $display("FAIL en_cancel_status: got %h want %h", v, model_status());
    else passed++;
    // re-enable: phase must restart from 0
    bus_write(R_CTRL, ctrl_word(1));
    for (int i = 0; i < 7; i++) begin
      wait_pulse(got, s, c);
      model_tick();
      checks++;
      if (!got || s !== 8'(m_last)) $display("FAIL en_restart_sample[%0d]: got %h want %h", i, s, 8'(m_last));
      else passed++;
    end
    bus_write(R_CTRL, ctrl_word(0));
    model_reset();
    npulse = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sample_valid) npulse++;
    end
    checks++;
    if (npulse != 0 || sample !== 8'h00) $display("FAIL en_midnote: pulses=%0d sample=%h want 0 and 00", npulse, sample);
    else passed++;
    bus_read(R_STAT, v);
    checks++;
    if (v !== model_status()) $display("FAIL en_midnote_status: got %h want %h", v, model_status());
    else passed++;
  endtask

  task automatic test_random();
    bit got; logic [7:0] s; int c, prev;
    logic [31:0] v;
    prev = 0;
    bus_write(R_CTRL, 0); model_reset();
    m_inc  = $urandom_range(1, 32'hFFFFFF);
    m_att  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 32'h5000);
    m_rel  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 32'h5000);
    m_wave = $urandom_range(0, 3); m_gate = 1;
    bus_write(R_PINC, m_inc); bus_write(R_ATT, m_att); bus_write(R_REL, m_rel);
    bus_write(R_CTRL, ctrl_word(1));
    for (int i = 0; i < 60; i++) begin
      wait_pulse(got, s, c);
      model_tick();
      checks++;
      if (!got || s !== 8'(m_last)) $display("FAIL rand_sample[%0d]: got %h (pulse=%0d) want %h", i, s, got, 8'(m_last));
      else passed++;
      if (i > 0) begin
        checks++;
        if (c - prev != DIV) $display("FAIL rand_spacing[%0d]: got %0d want %0d", i, c - prev, DIV);
        else passed++;
      end
      prev = c;
      if ($urandom_range(0, 3) == 0) begin
        m_gate = 1 - m_gate; m_wave = $urandom_range(0, 3);
        bus_write(R_CTRL, ctrl_word(1));
      end
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          m_att = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 32'h5000);
          bus_write(R_ATT, m_att);
        end else begin
          m_rel = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 32'h5000);
          bus_write(R_REL, m_rel);
        end
      end
      if (i % 2 == 0) begin
        bus_read(R_STAT, v);
        checks++;
        if (v !== model_status()) $display("FAIL rand_status[%0d]: got %h want %h", i, v, model_status());
        else passed++;
      end else begin
        bus_read(R_SAMP, v);
        checks++;
        if (v !== 32'(m_last)) $display("FAIL rand_sample_reg[%0d]: got %h want %h", i, v, 32'(m_last));
        else passed++;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_regs();
    test_square();
    test_async_reset();
    test_attack_release();
    test_enable_clear();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
